// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ifu_pkg;

    localparam int IFU_PC_STEP = 4;
    localparam int IFU_IR_W    = 32;
    localparam int IFU_PC_W    = 32;

    // Buffer word layout at default widths: instruction in the upper field, its PC in the lower.
    typedef struct packed {
        logic [IFU_IR_W-1:0] ir;
        logic [IFU_PC_W-1:0] pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Handshake bundle between the prefetch unit, instruction memory and the execute stage.
interface ifu_prefetch_if #(
    parameter int PC_W = 32,
    parameter int IR_W = 32
);
    logic            redirect_vld;
    logic [PC_W-1:0] redirect_pc;

    logic            ifetch_req_vld;
    logic            ifetch_req_rdy;
    logic [PC_W-1:0] ifetch_req_pc;

    logic            ifetch_rsp_vld;
    logic            ifetch_rsp_rdy;
    logic [IR_W-1:0] ifetch_rsp_ir;

    logic            iexec_req_vld;
    logic            iexec_req_rdy;
    logic [IR_W-1:0] iexec_req_ir;
    logic [PC_W-1:0] iexec_req_pc;

    modport master (
        input  redirect_vld, redirect_pc,
        output ifetch_req_vld, ifetch_req_pc,
        input  ifetch_req_rdy,
        input  ifetch_rsp_vld, ifetch_rsp_ir,
        output ifetch_rsp_rdy,
        output iexec_req_vld, iexec_req_ir, iexec_req_pc,
        input  iexec_req_rdy
    );

    modport slave (
        output redirect_vld, redirect_pc,
        input  ifetch_req_vld, ifetch_req_pc,
        output ifetch_req_rdy,
        output ifetch_rsp_vld, ifetch_rsp_ir,
        input  ifetch_rsp_rdy,
        input  iexec_req_vld, iexec_req_ir, iexec_req_pc,
        output iexec_req_rdy
    );

endinterface

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a combinational head output.
module ifu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic [WIDTH-1:0]           head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      cnt <= cnt + CNT_W'(1);
            else if (pop && !push) cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues sequential fetches, buffers responses, drops stale ones after redirects.
// Define IFU_PREFETCH_BYPASS_EN to forward a response straight to execute when the buffer is empty.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter int              IR_W       = 32,
    parameter int              MAX_OUTST  = 2,
    parameter int              IBUF_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst,
    ifu_prefetch_if.master bus
);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int BUF_W = $clog2(IBUF_DEPTH + 1);
    localparam int SUM_W = BUF_W + 1;
    localparam int ENT_W = IR_W + PC_W;

    logic [PC_W-1:0]  fetch_pc;
    logic [OUT_W-1:0] inflight;
    logic [OUT_W-1:0] drop_cnt;
    logic [BUF_W-1:0] ibuf_cnt;
    logic [PC_W-1:0]  rsp_pc;
    logic [ENT_W-1:0] ibuf_head;
    logic             room;
    logic             req_hs;
    logic             rsp_hs;
    logic             keep;
    logic             exec_hs;
    logic             ibuf_push;
    logic             ibuf_pop;

    // Buffer space is reserved when a request is issued, so responses can always be accepted.
    assign room   = (SUM_W'(inflight) + SUM_W'(ibuf_cnt)) < SUM_W'(IBUF_DEPTH);

    assign bus.ifetch_req_vld = ~rst & ~bus.redirect_vld & (inflight < OUT_W'(MAX_OUTST)) & room;
    assign bus.ifetch_req_pc  = fetch_pc;
    assign bus.ifetch_rsp_rdy = 1'b1;

    assign req_hs = bus.ifetch_req_vld & bus.ifetch_req_rdy;
    assign rsp_hs = bus.ifetch_rsp_vld;
    assign keep   = rsp_hs & ~bus.redirect_vld & (drop_cnt == '0);

`ifdef IFU_PREFETCH_BYPASS_EN
    logic bypass;

    assign bypass            = keep & (ibuf_cnt == '0);
    assign bus.iexec_req_vld = ~rst & ~bus.redirect_vld & ((ibuf_cnt != '0) | keep);
    assign bus.iexec_req_ir  = bypass ? bus.ifetch_rsp_ir : ibuf_head[ENT_W-1 -: IR_W];
    assign bus.iexec_req_pc  = bypass ? rsp_pc : ibuf_head[PC_W-1:0];
    assign ibuf_push         = keep & ~(bypass & bus.iexec_req_rdy);
`else
    assign bus.iexec_req_vld = ~rst & ~bus.redirect_vld & (ibuf_cnt != '0);
    assign bus.iexec_req_ir  = ibuf_head[ENT_W-1 -: IR_W];
    assign bus.iexec_req_pc  = ibuf_head[PC_W-1:0];
    assign ibuf_push         = keep;
`endif

    assign exec_hs  = bus.iexec_req_vld & bus.iexec_req_rdy;
    assign ibuf_pop = exec_hs & (ibuf_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   fetch_pc <= RESET_PC;
        else if (bus.redirect_vld) fetch_pc <= bus.redirect_pc;
        else if (req_hs)           fetch_pc <= fetch_pc + PC_W'(IFU_PC_STEP);
    end

    // Every request still in flight at a redirect belongs to the old path and must be discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              drop_cnt <= '0;
        else if (bus.redirect_vld)            drop_cnt <= inflight - OUT_W'(rsp_hs);
        else if (rsp_hs && drop_cnt != '0)    drop_cnt <= drop_cnt - OUT_W'(1);
    end

    // The PC FIFO occupancy is exactly the number of requests in flight.
    ifu_sync_fifo #(
        .WIDTH (PC_W),
        .DEPTH (MAX_OUTST)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_hs),
        .push_data (fetch_pc),
        .pop       (rsp_hs),
        .flush     (1'b0),
        .cnt       (inflight),
        .head      (rsp_pc)
    );

    ifu_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .push      (ibuf_push),
        .push_data ({bus.ifetch_rsp_ir, rsp_pc}),
        .pop       (ibuf_pop),
        .flush     (bus.redirect_vld),
        .cnt       (ibuf_cnt),
        .head      (ibuf_head)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch; honours IFU_PREFETCH_BYPASS_EN for latency expectations.
module tb_ifu_prefetch;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic auto_mem;

    logic [31:0] pend_q[$];
    logic [31:0] req_log[$];
    logic [31:0] exec_pc_log[$];
    logic [31:0] exec_ir_log[$];

    logic        s_req_vld;
    logic [31:0] s_req_pc;
    logic        s_rsp_rdy;
    logic        s_exec_vld;
    logic [31:0] s_exec_pc;
    logic [31:0] s_exec_ir;

`ifdef IFU_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    ifu_prefetch_if #(.PC_W(32), .IR_W(32)) bus ();

    ifu_prefetch #(
        .PC_W       (32),
        .IR_W       (32),
        .MAX_OUTST  (2),
        .IBUF_DEPTH (4),
        .RESET_PC   (32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_ir(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic idle_inputs();
        bus.redirect_vld   = 1'b0;
        bus.redirect_pc    = '0;
        bus.ifetch_req_rdy = 1'b0;
        bus.ifetch_rsp_vld = 1'b0;
        bus.ifetch_rsp_ir  = '0;
        bus.iexec_req_rdy  = 1'b0;
    endtask

    task automatic assert_reset();
        rst      = 1'b1;
        auto_mem = 1'b0;
        idle_inputs();
        pend_q.delete();
        req_log.delete();
        exec_pc_log.delete();
        exec_ir_log.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
    endtask

    // One clock: apply memory model, sample outputs mid-cycle, log handshakes, advance past the edge.
    task automatic cycle();
        logic hs;
        if (auto_mem) begin
            if (pend_q.size() != 0) begin
                bus.ifetch_rsp_vld = 1'b1;
                bus.ifetch_rsp_ir  = mem_ir(pend_q[0]);
            end else begin
                bus.ifetch_rsp_vld = 1'b0;
                bus.ifetch_rsp_ir  = '0;
            end
        end
        #1;
        s_req_vld  = bus.ifetch_req_vld;
        s_req_pc   = bus.ifetch_req_pc;
        s_rsp_rdy  = bus.ifetch_rsp_rdy;
        s_exec_vld = bus.iexec_req_vld;
        s_exec_pc  = bus.iexec_req_pc;
        s_exec_ir  = bus.iexec_req_ir;
        hs = s_req_vld & bus.ifetch_req_rdy;
        if (hs) req_log.push_back(s_req_pc);
        if (s_exec_vld && bus.iexec_req_rdy) begin
            exec_pc_log.push_back(s_exec_pc);
            exec_ir_log.push_back(s_exec_ir);
        end
        if (auto_mem) begin
            if (bus.ifetch_rsp_vld && pend_q.size() != 0) void'(pend_q.pop_front());
            if (hs) pend_q.push_back(s_req_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        #1;
        n_tests++;
        if (bus.ifetch_req_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_req_vld: got %b want 0", bus.ifetch_req_vld);
        end
        n_tests++;
        if (bus.iexec_req_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_exec_vld: got %b want 0", bus.iexec_req_vld);
        end
        n_tests++;
        if (bus.ifetch_req_pc !== 32'h100) begin
            n_fail++; $display("FAIL reset_pc: got %h want 00000100", bus.ifetch_req_pc);
        end
        n_tests++;
        if (bus.ifetch_rsp_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_rsp_rdy: got %b want 1", bus.ifetch_rsp_rdy);
        end
        release_reset();
        bus.ifetch_req_rdy = 1'b0;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b1 || s_req_pc !== 32'h100) begin
            n_fail++; $display("FAIL first_req_after_reset: got vld=%b pc=%h want vld=1 pc=00000100", s_req_vld, s_req_pc);
        end
    endtask

    task automatic test_stream();
        int exp_exec;
        assert_reset();
        release_reset();
        auto_mem           = 1'b1;
        bus.ifetch_req_rdy = 1'b1;
        bus.iexec_req_rdy  = 1'b1;
        repeat (12) cycle();
        n_tests++;
        if (req_log.size() !== 12) begin
            n_fail++; $display("FAIL stream_req_count: got %0d want 12", req_log.size());
        end
        for (int i = 0; i < 12 && i < req_log.size(); i++) begin
            n_tests++;
            if (req_log[i] !== 32'h100 + 32'(4 * i)) begin
                n_fail++; $display("FAIL stream_req_pc[%0d]: got %h want %h", i, req_log[i], 32'h100 + 32'(4 * i));
            end
        end
        exp_exec = BYP ? 11 : 10;
        n_tests++;
        if (exec_pc_log.size() !== exp_exec) begin
            n_fail++; $display("FAIL stream_exec_count: got %0d want %0d", exec_pc_log.size(), exp_exec);
        end
        for (int i = 0; i < exp_exec && i < exec_pc_log.size(); i++) begin
            n_tests++;
            if (exec_pc_log[i] !== 32'h100 + 32'(4 * i) || exec_ir_log[i] !== mem_ir(32'h100 + 32'(4 * i))) begin
                n_fail++; $display("FAIL stream_exec[%0d]: got pc=%h ir=%h want pc=%h ir=%h", i, exec_pc_log[i],
                                   exec_ir_log[i], 32'h100 + 32'(4 * i), mem_ir(32'h100 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_reset_mid();
        assert_reset();
        release_reset();
        auto_mem           = 1'b1;
        bus.ifetch_req_rdy = 1'b1;
        bus.iexec_req_rdy  = 1'b0;
        repeat (4) cycle();
        assert_reset();
        n_tests++;
        if (bus.ifetch_req_vld !== 1'b0 || bus.iexec_req_vld !== 1'b0) begin
            n_fail++; $display("FAIL midreset_vld: got req=%b exec=%b want 0 0", bus.ifetch_req_vld, bus.iexec_req_vld);
        end
        release_reset();
        bus.iexec_req_rdy = 1'b1;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b1 || s_req_pc !== 32'h100 || s_exec_vld !== 1'b0) begin
            n_fail++; $display("FAIL midreset_restart: got req=%b pc=%h exec=%b want 1 00000100 0", s_req_vld, s_req_pc, s_exec_vld);
        end
    endtask

    task automatic test_backpressure();
        logic rdy_ok;
        assert_reset();
        release_reset();
        auto_mem           = 1'b1;
        bus.ifetch_req_rdy = 1'b1;
        bus.iexec_req_rdy  = 1'b0;
        rdy_ok             = 1'b1;
        repeat (10) begin
            cycle();
            if (s_rsp_rdy !== 1'b1) rdy_ok = 1'b0;
        end
        n_tests++;
        if (req_log.size() !== 4) begin
            n_fail++; $display("FAIL bp_req_count: got %0d want 4", req_log.size());
        end
        n_tests++;
        if (s_req_vld !== 1'b0) begin
            n_fail++; $display("FAIL bp_req_vld_full: got %b want 0", s_req_vld);
        end
        n_tests++;
        if (s_exec_vld !== 1'b1) begin
            n_fail++; $display("FAIL bp_exec_vld: got %b want 1", s_exec_vld);
        end
        n_tests++;
        if (rdy_ok !== 1'b1) begin
            n_fail++; $display("FAIL bp_rsp_rdy: got %b want 1", rdy_ok);
        end
        bus.iexec_req_rdy = 1'b1;
        repeat (4) cycle();
        n_tests++;
        if (exec_pc_log.size() !== 4) begin
            n_fail++; $display("FAIL bp_drain_count: got %0d want 4", exec_pc_log.size());
        end
        for (int i = 0; i < 4 && i < exec_pc_log.size(); i++) begin
            n_tests++;
            if (exec_pc_log[i] !== 32'h100 + 32'(4 * i)) begin
                n_fail++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, exec_pc_log[i], 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        assert_reset();
        release_reset();
        bus.ifetch_req_rdy = 1'b1;
        bus.iexec_req_rdy  = 1'b1;
        cycle();
        cycle();
        bus.redirect_vld = 1'b1;
        bus.redirect_pc  = 32'h2000;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b0 || s_exec_vld !== 1'b0) begin
            n_fail++; $display("FAIL redir_cycle_vld: got req=%b exec=%b want 0 0", s_req_vld, s_exec_vld);
        end
        bus.redirect_vld   = 1'b0;
        bus.ifetch_rsp_vld = 1'b1;
        bus.ifetch_rsp_ir  = 32'hBAD0_0100;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b0 || s_req_pc !== 32'h2000 || s_exec_vld !== 1'b0) begin
            n_fail++; $display("FAIL redir_drop1: got req=%b pc=%h exec=%b want 0 00002000 0", s_req_vld, s_req_pc, s_exec_vld);
        end
        bus.ifetch_rsp_ir = 32'hBAD0_0104;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b1 || s_req_pc !== 32'h2000 || s_exec_vld !== 1'b0) begin
            n_fail++; $display("FAIL redir_drop2: got req=%b pc=%h exec=%b want 1 00002000 0", s_req_vld, s_req_pc, s_exec_vld);
        end
        bus.ifetch_rsp_ir  = 32'hCAFE_2000;
        bus.ifetch_req_rdy = 1'b0;
        cycle();
        bus.ifetch_rsp_vld = 1'b0;
        cycle();
        n_tests++;
        if (exec_pc_log.size() !== 1) begin
            n_fail++; $display("FAIL redir_exec_count: got %0d want 1", exec_pc_log.size());
        end else if (exec_pc_log[0] !== 32'h2000 || exec_ir_log[0] !== 32'hCAFE_2000) begin
            n_fail++; $display("FAIL redir_exec: got pc=%h ir=%h want 00002000 cafe2000", exec_pc_log[0], exec_ir_log[0]);
        end
    endtask

    task automatic test_redirect_with_rsp();
        assert_reset();
        release_reset();
        bus.ifetch_req_rdy = 1'b1;
        bus.iexec_req_rdy  = 1'b1;
        cycle();
        cycle();
        bus.redirect_vld   = 1'b1;
        bus.redirect_pc    = 32'h3000;
        bus.ifetch_rsp_vld = 1'b1;
        bus.ifetch_rsp_ir  = 32'hBAD0_0100;
        cycle();
        n_tests++;
        if (s_exec_vld !== 1'b0) begin
            n_fail++; $display("FAIL redrsp_exec_vld: got %b want 0", s_exec_vld);
        end
        bus.redirect_vld   = 1'b0;
        bus.ifetch_req_rdy = 1'b0;
        bus.ifetch_rsp_ir  = 32'hBAD0_0104;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b1 || s_req_pc !== 32'h3000 || s_exec_vld !== 1'b0) begin
            n_fail++; $display("FAIL redrsp_after: got req=%b pc=%h exec=%b want 1 00003000 0", s_req_vld, s_req_pc, s_exec_vld);
        end
        bus.ifetch_rsp_vld = 1'b0;
        bus.ifetch_req_rdy = 1'b1;
        cycle();
        bus.ifetch_req_rdy = 1'b0;
        bus.ifetch_rsp_vld = 1'b1;
        bus.ifetch_rsp_ir  = 32'hCAFE_3000;
        cycle();
        bus.ifetch_rsp_vld = 1'b0;
        cycle();
        n_tests++;
        if (exec_pc_log.size() !== 1) begin
            n_fail++; $display("FAIL redrsp_exec_count: got %0d want 1", exec_pc_log.size());
        end else if (exec_pc_log[0] !== 32'h3000 || exec_ir_log[0] !== 32'hCAFE_3000) begin
            n_fail++; $display("FAIL redrsp_exec: got pc=%h ir=%h want 00003000 cafe3000", exec_pc_log[0], exec_ir_log[0]);
        end
    endtask

    task automatic test_back_to_back();
        assert_reset();
        release_reset();
        bus.ifetch_req_rdy = 1'b1;
        bus.iexec_req_rdy  = 1'b1;
        cycle();
        bus.redirect_vld = 1'b1;
        bus.redirect_pc  = 32'h4000;
        cycle();
        bus.redirect_pc    = 32'h5000;
        bus.ifetch_rsp_vld = 1'b1;
        bus.ifetch_rsp_ir  = 32'hBAD0_0100;
        cycle();
        bus.redirect_vld   = 1'b0;
        bus.ifetch_rsp_vld = 1'b0;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b1 || s_req_pc !== 32'h5000) begin
            n_fail++; $display("FAIL b2b_req: got vld=%b pc=%h want 1 00005000", s_req_vld, s_req_pc);
        end
        bus.ifetch_req_rdy = 1'b0;
        bus.ifetch_rsp_vld = 1'b1;
        bus.ifetch_rsp_ir  = 32'hCAFE_5000;
        cycle();
        bus.ifetch_rsp_vld = 1'b0;
        cycle();
        n_tests++;
        if (exec_pc_log.size() !== 1) begin
            n_fail++; $display("FAIL b2b_exec_count: got %0d want 1", exec_pc_log.size());
        end else if (exec_pc_log[0] !== 32'h5000 || exec_ir_log[0] !== 32'hCAFE_5000) begin
            n_fail++; $display("FAIL b2b_exec: got pc=%h ir=%h want 00005000 cafe5000", exec_pc_log[0], exec_ir_log[0]);
        end
    endtask

    task automatic test_pc_wrap();
        assert_reset();
        release_reset();
        bus.ifetch_req_rdy = 1'b1;
        bus.redirect_vld   = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b0) begin
            n_fail++; $display("FAIL wrap_redir_vld: got %b want 0", s_req_vld);
        end
        bus.redirect_vld = 1'b0;
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b1 || s_req_pc !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_first: got vld=%b pc=%h want 1 fffffffc", s_req_vld, s_req_pc);
        end
        cycle();
        n_tests++;
        if (s_req_vld !== 1'b1 || s_req_pc !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_next: got vld=%b pc=%h want 1 00000000", s_req_vld, s_req_pc);
        end
    endtask

    task automatic test_bypass_latency();
        assert_reset();
        release_reset();
        bus.ifetch_req_rdy = 1'b1;
        bus.iexec_req_rdy  = 1'b1;
        cycle();
        bus.ifetch_req_rdy = 1'b0;
        bus.ifetch_rsp_vld = 1'b1;
        bus.ifetch_rsp_ir  = 32'h1111_2222;
        cycle();
        n_tests++;
        if (s_exec_vld !== BYP) begin
            n_fail++; $display("FAIL lat_rsp_cycle: got exec_vld=%b want %b", s_exec_vld, BYP);
        end
        bus.ifetch_rsp_vld = 1'b0;
        cycle();
        n_tests++;
        if (s_exec_vld !== !BYP) begin
            n_fail++; $display("FAIL lat_next_cycle: got exec_vld=%b want %b", s_exec_vld, !BYP);
        end
        n_tests++;
        if (exec_pc_log.size() !== 1) begin
            n_fail++; $display("FAIL lat_exec_count: got %0d want 1", exec_pc_log.size());
        end else if (exec_pc_log[0] !== 32'h100 || exec_ir_log[0] !== 32'h1111_2222) begin
            n_fail++; $display("FAIL lat_exec: got pc=%h ir=%h want 00000100 11112222", exec_pc_log[0], exec_ir_log[0]);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        auto_mem = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_reset_mid();
        test_backpressure();
        test_redirect();
        test_redirect_with_rsp();
        test_back_to_back();
        test_pc_wrap();
        test_bypass_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL have parameter IR_W, default 32, instruction width in bits.
REQ-003 SHALL have parameter MAX_OUTST, default 2, maximum in-flight fetch requests (1..8).
REQ-004 SHALL have parameter IBUF_DEPTH, default 4, instruction buffer entries (≥ MAX_OUTST, power of two).
REQ-005 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports redirect_vld  input  1, and redirect_pc  input  PC_W: a control-flow change to a new PC.
REQ-009 SHALL have ports ifetch_req_vld  output  1, ifetch_req_rdy  input  1, and ifetch_req_pc  output  PC_W.
REQ-010 SHALL have ports ifetch_rsp_vld  input  1, ifetch_rsp_rdy  output  1, and ifetch_rsp_ir  input  IR_W; responses return in request order.
REQ-011 SHALL have ports iexec_req_vld  output  1, iexec_req_rdy  input  1, iexec_req_ir  output  IR_W, and iexec_req_pc  output  PC_W.

Function
REQ-012 A handshake SHALL occur only on a cycle with vld=1 and rdy=1; unaccepted vld/payload SHALL hold stable unless redirect_vld=1.
REQ-013 fetch_pc SHALL drive ifetch_req_pc; it advances to fetch_pc+4 mod 2^PC_W on each ifetch request handshake, wrapping all-ones-minus-3 to 0.
REQ-014 Counters: inflight (0..MAX_OUTST) and ibuf_cnt (0..IBUF_DEPTH).
REQ-015 ifetch_req_vld SHALL be ~redirect_vld & (inflight < MAX_OUTST) & (inflight + ibuf_cnt < IBUF_DEPTH).
REQ-016 ifetch_rsp_rdy SHALL be constant 1; space is reserved at request time.
REQ-017 The PC of each accepted request SHALL be pushed into a PC FIFO (depth MAX_OUTST).
REQ-018 On each response, that PC SHALL be popped and paired with ifetch_rsp_ir.
REQ-019 A kept response SHALL push {ir, pc} into the instruction buffer; iexec_req_vld = (ibuf_cnt ≠ 0) & ~redirect_vld.
REQ-020 The iexec_req_ir/pc pair SHALL be driven from the buffer head.
REQ-021 Simultaneous request, response, and iexec handshakes SHALL update the counters net: inflight += req − rsp; ibuf_cnt += push − pop.
REQ-022 On redirect_vld=1, the instruction buffer SHALL be emptied in the same edge.
REQ-023 On redirect_vld=1, fetch_pc SHALL load redirect_pc.
REQ-024 On redirect_vld=1, drop_cnt SHALL load inflight − (rsp handshake this cycle).
REQ-025 A response arriving on a redirect cycle SHALL be discarded.
REQ-026 While drop_cnt>0, each response SHALL be discarded, decrement drop_cnt and inflight, and pop the PC FIFO.
REQ-027 While drop_cnt>0, new fetches SHALL still issue.
REQ-028 Back-to-back redirects SHALL each reload fetch_pc; drop_cnt SHALL be recomputed each time.
REQ-029 The first fetch after redirect SHALL be issued the cycle after redirect_vld, at redirect_pc.
REQ-030 Steady state with ifetch_req_rdy=1, 1-cycle memory, and iexec_req_rdy=1 SHALL sustain one instruction per cycle.

Reset
REQ-031 While rst=1: fetch_pc=RESET_PC; inflight, ibuf_cnt, drop_cnt=0; PC FIFO and instruction buffer empty.
REQ-032 While rst=1, ifetch_req_vld=0 and iexec_req_vld=0.
REQ-033 Reset asserted mid-transaction SHALL abandon all in-flight requests; the memory side is reset together with this block.
REQ-034 ifetch_req_vld SHALL assert in the first cycle after rst deasserts.

Configuration
REQ-035 Macro IFU_PREFETCH_BYPASS_EN SHALL control an empty-buffer bypass.
REQ-036 With IFU_PREFETCH_BYPASS_EN defined: if ibuf_cnt=0, a kept response SHALL be presented on iexec_req_* in the same cycle.
REQ-037 If that bypassed response is handshaken, it SHALL not be written to the buffer; otherwise it is written normally (0-cycle latency).
REQ-038 Without IFU_PREFETCH_BYPASS_EN: response handshake to iexec_req_vld SHALL be exactly 1 cycle.

Structure
REQ-039 Package ifu_pkg SHALL hold the ibuf_entry_t struct {ir, pc} and the PC step constant IFU_PC_STEP=4.
REQ-040 Sub-module ifu_sync_fifo SHALL be a parametrised width/depth synchronous FIFO with push, pop, flush, cnt, and head.
REQ-041 ifu_sync_fifo SHALL be instantiated twice: PC FIFO (width PC_W) and instruction buffer (width IR_W+PC_W).

Verification
REQ-042 Reset release with RESET_PC=0x100, memory 1-cycle, iexec_req_rdy=1 -> ifetch PCs 0x100, 0x104, 0x108...; iexec delivers in order at 1 instruction/cycle.
REQ-043 iexec_req_rdy=0 for 10 cycles, defaults -> at most 4 requests accepted; ifetch_req_vld=0 once inflight+ibuf_cnt=4; ifetch_rsp_rdy stays 1.
REQ-044 Redirect to 0x2000 with 2 in flight -> both later responses dropped; next ifetch_req_pc=0x2000; first iexec_req_pc=0x2000.
REQ-045 Redirect on the same cycle as a response -> that response discarded and drop_cnt=1.
REQ-046 fetch_pc=0xFFFF_FFFC -> the following request PC is 0x0000_0000.
REQ-047 With IFU_PREFETCH_BYPASS_EN and the buffer empty -> iexec_req_vld rises in the response cycle; without it, one cycle later.
